// File: rtl/zram_ctrl.sv
// zram_ctrl: DRAM controller for Zorro II FastRAM boards.
// Turns 68000 bus cycles into per-bank RAS/CAS sequences with a built-in
// row/column mux, and runs timer-driven CAS-before-RAS refresh.
// A pending-refresh counter arbitrates refresh against bus accesses.
// Optional feature macro REFRESH_QUEUE_EN: when defined, up to four missed
// refresh ticks are queued (PMAX = 4); otherwise a single pending flag
// is kept (PMAX = 1).
//
// Handshake: a request is !ASn & SEL sampled in IDLE. The cycle completes
// with ACKn low (from CAS onwards) and ends when ASn returns high; ASn high
// before CAS aborts the cycle without CAS or ACKn.
//
// All DRAM outputs are registered decodes of the current state, so they
// appear one clock after the FSM enters a state.
module zram_ctrl #(
  parameter int BANKS          = 4,
  parameter int MA_BITS        = 10,
  parameter int REFRESH_PERIOD = 110,
  parameter int T_RP           = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               SEL,
  input  logic               ASn,
  input  logic               UDSn,
  input  logic               LDSn,
  input  logic               RWn,
  input  logic [23:1]        ADDR,
  output logic [MA_BITS-1:0] MADDR,
  output logic [BANKS-1:0]   RASn,
  output logic               UCASn,
  output logic               LCASn,
  output logic               MEMWn,
  output logic               ACKn,
  output logic               REF_OVF,
  output logic [2:0]         dbg_state_o,
  output logic [2:0]         dbg_pending_o
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TW = $clog2(REFRESH_PERIOD);
  localparam int CW = (T_RP > 1) ? $clog2(T_RP) : 1;

`ifdef REFRESH_QUEUE_EN
  localparam logic [2:0] PMAX = 3'd4;
`else
  localparam logic [2:0] PMAX = 3'd1;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROW     = 3'd1,
    COL     = 3'd2,
    CAS     = 3'd3,
    HOLD    = 3'd4,
    PRE     = 3'd5,
    REF_CAS = 3'd6,
    REF_RAS = 3'd7
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       pre_cnt_q;
  logic                ras_cnt_q;
  logic [MA_BITS-1:0]  row_q;
  logic [MA_BITS-1:0]  col_q;
  logic [BW-1:0]       bank_q;
  logic                rw_q;
  logic [MA_BITS-1:0]  maddr_q;
  logic [BANKS-1:0]    rasn_q;
  logic                ucasn_q;
  logic                lcasn_q;
  logic                memwn_q;
  logic                ackn_q;

  logic [TW-1:0]       timer_q, timer_d;
  logic [2:0]          pending_q, pending_d;
  logic                ovf_q, ovf_d;

  logic                req;
  logic                tick;
  logic                ref_done;
  logic [BW-1:0]       bank_addr;
  logic [BANKS-1:0]    bank_dec;
  logic                unused_addr;

  assign req      = !ASn && SEL;
  assign tick     = (timer_q == '0);
  assign ref_done = (state_q == REF_RAS) && (ras_cnt_q == 1'b0);

  // Bits above the bank field are decoded upstream by autoconfig.
  assign unused_addr = ^ADDR;

  generate
    if (BANKS > 1) begin : g_bank
      assign bank_addr = ADDR[2*MA_BITS+BW:2*MA_BITS+1];
    end else begin : g_one_bank
      assign bank_addr = '0;
    end
  endgenerate

  // One-hot select of the latched bank, used for the active-low RAS bus.
  always_comb begin
    bank_dec = '0;
    for (int i = 0; i < BANKS; i++) begin
      bank_dec[i] = (bank_q == BW'(i));
    end
  end

  // Refresh timer reload and pending-refresh accounting; a tick that
  // coincides with a completed refresh cancels out.
  always_comb begin
    timer_d   = (timer_q == '0) ? TW'(REFRESH_PERIOD - 1) : timer_q - 1'b1;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (tick && !ref_done) begin
      if (pending_q == PMAX) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end else if (!tick && ref_done) begin
      pending_d = pending_q - 3'd1;
    end
  end

  // Timer, pending counter and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q   <= TW'(REFRESH_PERIOD - 1);
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // Main FSM: next-state selection plus registered decode of the current state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      ras_cnt_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      bank_q    <= '0;
      rw_q      <= 1'b1;
      maddr_q   <= '0;
      rasn_q    <= '1;
      ucasn_q   <= 1'b1;
      lcasn_q   <= 1'b1;
      memwn_q   <= 1'b1;
      ackn_q    <= 1'b1;
    end else begin
      case (state_q)
        ROW: begin
          rasn_q  <= ~bank_dec;
          maddr_q <= row_q;
          ucasn_q <= 1'b1;
          lcasn_q <= 1'b1;
          memwn_q <= rw_q;
          ackn_q  <= 1'b1;
        end
        COL: begin
          rasn_q  <= ~bank_dec;
          maddr_q <= col_q;
          ucasn_q <= 1'b1;
          lcasn_q <= 1'b1;
          memwn_q <= rw_q;
          ackn_q  <= 1'b1;
        end
        CAS: begin
          rasn_q  <= ~bank_dec;
          maddr_q <= col_q;
          ucasn_q <= UDSn;
          lcasn_q <= LDSn;
          memwn_q <= rw_q;
          ackn_q  <= 1'b0;
        end
        HOLD: begin
          // Late data strobes join the column strobes already asserted.
          ucasn_q <= ucasn_q & UDSn;
          lcasn_q <= lcasn_q & LDSn;
        end
        REF_CAS: begin
          rasn_q  <= '1;
          ucasn_q <= 1'b0;
          lcasn_q <= 1'b0;
          memwn_q <= 1'b1;
          ackn_q  <= 1'b1;
        end
        REF_RAS: begin
          rasn_q  <= '0;
          ucasn_q <= 1'b0;
          lcasn_q <= 1'b0;
          memwn_q <= 1'b1;
          ackn_q  <= 1'b1;
        end
        default: begin
          rasn_q  <= '1;
          ucasn_q <= 1'b1;
          lcasn_q <= 1'b1;
          memwn_q <= 1'b1;
          ackn_q  <= 1'b1;
        end
      endcase

      case (state_q)
        IDLE: begin
          if (req) begin
            if (pending_q < PMAX) begin
              state_q <= ROW;
              row_q   <= ADDR[2*MA_BITS:MA_BITS+1];
              col_q   <= ADDR[MA_BITS:1];
              bank_q  <= bank_addr;
              rw_q    <= RWn;
            end else begin
              state_q <= REF_CAS;
            end
          end else if (pending_q != '0) begin
            state_q <= REF_CAS;
          end
        end
        ROW: begin
          if (ASn) begin
            state_q   <= PRE;
            pre_cnt_q <= CW'(T_RP - 1);
          end else begin
            state_q <= COL;
          end
        end
        COL: begin
          if (ASn) begin
            state_q   <= PRE;
            pre_cnt_q <= CW'(T_RP - 1);
          end else if (!UDSn || !LDSn) begin
            state_q <= CAS;
          end
        end
        CAS: state_q <= HOLD;
        HOLD: begin
          if (ASn) begin
            state_q   <= PRE;
            pre_cnt_q <= CW'(T_RP - 1);
          end
        end
        REF_CAS: begin
          state_q   <= REF_RAS;
          ras_cnt_q <= 1'b1;
        end
        REF_RAS: begin
          if (ras_cnt_q == 1'b0) begin
            state_q   <= PRE;
            pre_cnt_q <= CW'(T_RP - 1);
          end else begin
            ras_cnt_q <= 1'b0;
          end
        end
        PRE: begin
          if (pre_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            pre_cnt_q <= pre_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MADDR         = maddr_q;
  assign RASn          = rasn_q;
  assign UCASn         = ucasn_q;
  assign LCASn         = lcasn_q;
  assign MEMWn         = memwn_q;
  assign ACKn          = ackn_q;
  assign REF_OVF       = ovf_q;
  assign dbg_state_o   = state_q;
  assign dbg_pending_o = pending_q;

endmodule
